// File: rtl/tmc_spi_slave_if.sv
// tmc_spi_slave_if: SPI pins plus the local tx/rx handshake of tmc_spi_slave.
//   slave modport  : used by tmc_spi_slave (SPI pins in, MISO/status out).
//   master modport : used by whatever drives the SPI pins and the tx/rx side.
// Signals:
//   spi_sclk, spi_ss_n, spi_mosi : SPI inputs from the bus master (asynchronous)
//   spi_miso, spi_miso_oe        : slave-out data and its pad enable
//   tx_data, tx_load, tx_ready   : transmit holding-register load handshake
//   rx_data, rx_valid            : last received word and its one-cycle strobe
//   busy                         : synchronized SS_n is low
//   tx_underrun, underrun_clr    : sticky underrun flag and its clear
interface tmc_spi_slave_if #(
    parameter int unsigned DATA_W = 8
);
    logic              spi_sclk;
    logic              spi_ss_n;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              tx_underrun;
    logic              underrun_clr;

    modport slave (
        input  spi_sclk, spi_ss_n, spi_mosi, tx_data, tx_load, underrun_clr,
        output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun
    );

    modport master (
        output spi_sclk, spi_ss_n, spi_mosi, tx_data, tx_load, underrun_clr,
        input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun
    );
endinterface

// File: rtl/tmc_spi_slave.sv
// tmc_spi_slave: SPI mode-0 responder, oversampled in the clk_clk domain.
// Ports:
//   clk_clk        : system clock, at least 8x SCLK
//   reset_reset_n  : asynchronous active-low reset
//   bus            : tmc_spi_slave_if.slave (SPI pins, tx holding handshake, rx strobe,
//                    busy, sticky tx_underrun with underrun_clr)
// Build option: define TMC_SPI_SLAVE_LSB_FIRST_EN to shift bit 0 first in both directions;
// default is MSB first.
module tmc_spi_slave #(
    parameter int unsigned DATA_W = 8
) (
    input logic            clk_clk,
    input logic            reset_reset_n,
    tmc_spi_slave_if.slave bus
);
    localparam int unsigned CntW = $clog2(DATA_W);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    // Synchronizers: two flops each, plus a history flop on SCLK and SS_n for edges.
    logic [1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic       sclk_hist_q, ss_hist_q;
    // fill_q counts reset-release cycles until ss_sync_q[1] holds a real pin sample;
    // arm_q then requires SS_n seen high before a falling edge is accepted.
    logic [1:0] fill_q;
    logic       arm_q, arm_d;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              miso_q, miso_d;
    logic              oe_q, oe_d;
    logic              underrun_q, underrun_d;

    logic              sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_s;
    logic [DATA_W-1:0] tx_next, rx_next, word;
    logic              xfer, underrun_set;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_hist_q;
    assign sclk_fall = ~sclk_sync_q[1] & sclk_hist_q;
    assign ss_fall   = arm_q & ss_hist_q & ~ss_sync_q[1];
    assign ss_rise   = ~ss_hist_q & ss_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign arm_d     = arm_q | ((fill_q == 2'd2) & ss_sync_q[1]);

`ifdef TMC_SPI_SLAVE_LSB_FIRST_EN
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return w[0];
    endfunction
    assign tx_next = tx_shift_q >> 1;
    assign rx_next = (rx_shift_q >> 1) | (DATA_W'(mosi_s) << (DATA_W - 1));
`else
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return w[DATA_W-1];
    endfunction
    assign tx_next = tx_shift_q << 1;
    assign rx_next = (rx_shift_q << 1) | DATA_W'(mosi_s);
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sclk_sync_q <= 2'b00;
            ss_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sclk_hist_q <= 1'b0;
            ss_hist_q   <= 1'b1;
            fill_q      <= 2'd0;
            arm_q       <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], bus.spi_sclk};
            ss_sync_q   <= {ss_sync_q[0], bus.spi_ss_n};
            mosi_sync_q <= {mosi_sync_q[0], bus.spi_mosi};
            sclk_hist_q <= sclk_sync_q[1];
            ss_hist_q   <= ss_sync_q[1];
            if (fill_q != 2'd2) begin
                fill_q <= fill_q + 2'd1;
            end
            arm_q <= arm_d;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tx_shift_d   = tx_shift_q;
        rx_shift_d   = rx_shift_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        miso_d       = miso_q;
        oe_d         = oe_q;
        underrun_d   = underrun_q;
        xfer         = 1'b0;
        underrun_set = 1'b0;
        word         = '1;

        unique case (state_q)
            StIdle: begin
                if (ss_fall) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    oe_d    = 1'b1;
                    xfer    = 1'b1;
                end
            end
            StShift: begin
                // SS_n deselect wins over any SCLK edge seen in the same cycle.
                if (ss_rise) begin
                    state_d    = StIdle;
                    cnt_d      = '0;
                    oe_d       = 1'b0;
                    miso_d     = 1'b0;
                    rx_shift_d = '0;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_next;
                    if (cnt_q == LastBit) begin
                        cnt_d      = '0;
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end else if (sclk_fall) begin
                    if (cnt_q != '0) begin
                        tx_shift_d = tx_next;
                        miso_d     = first_bit(tx_next);
                    end else begin
                        xfer = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (xfer) begin
            if (hold_full_q) begin
                word        = hold_q;
                hold_full_d = 1'b0;
            end else if (bus.tx_load) begin
                // Bypass: the load is consumed here and the holding register stays empty.
                word = bus.tx_data;
            end else begin
                underrun_set = 1'b1;
            end
            tx_shift_d = word;
            miso_d     = first_bit(word);
        end else if (bus.tx_load && !hold_full_q) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end

        if (bus.underrun_clr) begin
            underrun_d = 1'b0;
        end
        if (underrun_set) begin
            underrun_d = 1'b1;
        end
    end

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = oe_q;
    assign bus.tx_ready    = ~hold_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.busy        = ~ss_hist_q;
    assign bus.tx_underrun = underrun_q;
endmodule
